// File: rtl/jpeg_enc_pkg.sv
// Shared constants and types for the JPEG encoder front end.
// Holds the converter depth, block geometry, pixel tag bit layout and controller states.
package jpeg_enc_pkg;

  localparam int LATENCY_RGB2YCBCR = 3;
  localparam int BLOCK_PIXELS      = 64;
  localparam int PIX_W             = 24;

  // Bit positions of the per-pixel tags that travel alongside the valid bits
  localparam int TAG_FIRST    = 0;
  localparam int TAG_BLK_LAST = 1;
  localparam int TAG_FRM_LAST = 2;
  localparam int TAG_W        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/rgb2ycbcr_ctrl_if.sv
// Pixel stream bundle around the colour converter controller.
// The master side is the upstream/downstream environment; the slave side is the controller.
interface rgb2ycbcr_ctrl_if;
  import jpeg_enc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_block_start;
  logic             out_block_end;
  logic             out_frame_end;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_block_start, out_block_end, out_frame_end
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_block_start, out_block_end, out_frame_end
  );

endinterface

// File: rtl/rgb2ycbcr_ctrl_pipe.sv
// Shift register of per-stage valid bits and tags that mirrors the converter pipeline.
// It only moves when the converter is enabled, so tags stay aligned with the converter data.
module stall_valid_pipe #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en_i,
  input  logic               valid_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic [LATENCY-1:0] valid_o,
  output logic [TAG_W-1:0]   tag_o
);

  logic [LATENCY-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else if (shift_en_i) begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= tag_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q[LATENCY-1];

endmodule

// File: rtl/rgb2ycbcr_ctrl.sv
// Flow controller for the 3-stage RGB-to-YCbCr converter: gates the converter enable,
// tracks pixel validity and block/frame tags through it, and counts completed blocks.
module rgb2ycbcr_ctrl #(
  parameter int LATENCY      = jpeg_enc_pkg::LATENCY_RGB2YCBCR,
  parameter int BLOCK_PIXELS = jpeg_enc_pkg::BLOCK_PIXELS,
  parameter int BLK_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rgb2ycbcr_ctrl_if.slave      bus,
  output logic                 conv_enable,
  output logic [23:0]          conv_data_in,
  input  logic [23:0]          conv_data_out,
  output logic [BLK_CNT_W-1:0] block_count,
  output logic                 frame_err,
  output logic                 busy
);
  import jpeg_enc_pkg::*;

  localparam int IDX_W = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_PIXELS - 1);

  ctrl_state_e          state_q, state_d;
  logic [IDX_W-1:0]     pixIdx_q, pixIdx_d;
  logic [BLK_CNT_W-1:0] blkCnt_q, blkCnt_d;
  logic                 frameErr_q, frameErr_d;

  logic [LATENCY-1:0]   stageValid;
  logic [TAG_W-1:0]     entryTag, outTag;
  logic                 outValid, adv, inFire, outFire;

  // A full output stage that downstream refuses freezes the whole converter
  assign outValid     = stageValid[LATENCY-1];
  assign adv          = !(outValid && !bus.out_ready);
  assign bus.in_ready = adv && (state_q != DRAIN) && !rst;
  assign inFire       = bus.in_valid && bus.in_ready;
  assign outFire      = outValid && bus.out_ready;
  assign conv_enable  = adv && (inFire || (|stageValid));
  assign conv_data_in = bus.in_data;

  assign bus.out_valid       = outValid;
  assign bus.out_data        = conv_data_out;
  assign bus.out_block_start = outValid && outTag[TAG_FIRST];
  assign bus.out_block_end   = outValid && outTag[TAG_BLK_LAST];
  assign bus.out_frame_end   = outValid && outTag[TAG_FRM_LAST];

  assign block_count = blkCnt_q;
  assign frame_err   = frameErr_q;
  assign busy        = (state_q != IDLE);

  // Bubbles enter with all-zero tags so stale markers never reach the output
  always_comb begin
    entryTag = '0;
    if (inFire) begin
      entryTag[TAG_FIRST]    = (pixIdx_q == '0);
      entryTag[TAG_BLK_LAST] = (pixIdx_q == LAST_IDX);
      entryTag[TAG_FRM_LAST] = bus.in_last;
    end
  end

  stall_valid_pipe #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (conv_enable),
    .valid_i    (inFire),
    .tag_i      (entryTag),
    .valid_o    (stageValid),
    .tag_o      (outTag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pixIdx_q   <= '0;
      blkCnt_q   <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pixIdx_q   <= pixIdx_d;
      blkCnt_q   <= blkCnt_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pixIdx_d   = pixIdx_q;
    blkCnt_d   = blkCnt_q;
    frameErr_d = frameErr_q;

    if (inFire) begin
      pixIdx_d   = bus.in_last ? '0 : pixIdx_q + 1'b1;
      frameErr_d = ((state_q == IDLE) ? 1'b0 : frameErr_q) |
                   (bus.in_last && (pixIdx_q != LAST_IDX));
    end

    // The frame's final block is implied by frame_end, so that pixel clears instead
    if (outFire) begin
      if (outTag[TAG_FRM_LAST]) begin
        blkCnt_d = '0;
      end else if (outTag[TAG_BLK_LAST] && !(&blkCnt_q)) begin
        blkCnt_d = blkCnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (inFire) begin
          state_d = bus.in_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (inFire && bus.in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outFire && outTag[TAG_FRM_LAST]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rgb2ycbcr_ctrl.sv
// Self-checking bench for rgb2ycbcr_ctrl with a behavioural 3-stage converter and a
// scoreboard of expected pixels, tags, block counts and handshake behaviour.
module tb_rgb2ycbcr_ctrl;
  import jpeg_enc_pkg::*;

  typedef struct {
    logic [23:0] data;
    logic        bs;
    logic        be;
    logic        fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        conv_enable;
  logic [23:0] conv_data_in;
  logic [23:0] conv_data_out;
  logic [15:0] block_count;
  logic        frame_err;
  logic        busy;

  rgb2ycbcr_ctrl_if bus ();

  rgb2ycbcr_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .conv_enable   (conv_enable),
    .conv_data_in  (conv_data_in),
    .conv_data_out (conv_data_out),
    .block_count   (block_count),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // JPEG integer colour transform, packed {Cr,Cb,Y}
  function automatic logic [23:0] ycc(input logic [23:0] rgb);
    int r, g, b, y, cb, cr;
    r  = int'(rgb[7:0]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[23:16]);
    y  = (77 * r + 150 * g + 29 * b) >>> 8;
    cb = ((-43 * r - 85 * g + 128 * b) >>> 8) + 128;
    cr = ((128 * r - 107 * g - 21 * b) >>> 8) + 128;
    return {cr[7:0], cb[7:0], y[7:0]};
  endfunction

  // Behavioural converter: three enabled register stages sharing the controller reset
  logic [23:0] cs1, cs2, cs3;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cs1 <= '0;
      cs2 <= '0;
      cs3 <= '0;
    end else if (conv_enable) begin
      cs1 <= ycc(conv_data_in);
      cs2 <= cs1;
      cs3 <= cs2;
    end
  end
  assign conv_data_out = cs3;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  exp_t        sb[$];
  exp_t        e;
  int          tbIdx;
  bit          tbBusy, tbErr, tbDrain, prevStall;
  logic [15:0] tbBlkCnt;
  logic [23:0] prevData;
  int          outCount = 0;
  int          fendCyc;
  bit          latArm, latAccSeen, latOutSeen;
  int          latAccCyc, latOutCyc;
  int          readyMode = 0;
  int          readyK = 0;

  // Monitor and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      tbIdx     = 0;
      tbBusy    = 0;
      tbErr     = 0;
      tbDrain   = 0;
      tbBlkCnt  = '0;
      prevStall = 0;
    end else begin
      checkOutput("busy", busy, tbBusy);
      checkOutput("frame_err", frame_err, tbErr);
      checkOutput("block_count", block_count, tbBlkCnt);
      checkOutput("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready) && !tbDrain);
      checkOutput("conv_enable", conv_enable,
                  !(bus.out_valid && !bus.out_ready) &&
                  ((bus.in_valid && bus.in_ready) || (sb.size() != 0)));
      if (prevStall) begin
        checkOutput("stall_valid", bus.out_valid, 1);
        checkOutput("stall_data", bus.out_data, prevData);
      end
      if (sb.size() == 0) checkOutput("spurious_out", bus.out_valid, 0);

      if (latArm && latAccSeen && !latOutSeen && bus.out_valid) begin
        latOutCyc  = cyc;
        latOutSeen = 1;
      end
      if (latArm && !latAccSeen && bus.in_valid && bus.in_ready) begin
        latAccCyc  = cyc;
        latAccSeen = 1;
      end

      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("out_data", bus.out_data, e.data);
        checkOutput("block_start", bus.out_block_start, e.bs);
        checkOutput("block_end", bus.out_block_end, e.be);
        checkOutput("frame_end", bus.out_frame_end, e.fe);
        outCount++;
        if (e.fe) begin
          tbBlkCnt = '0;
          tbBusy   = 0;
          tbDrain  = 0;
          fendCyc  = cyc;
        end else if (e.be && tbBlkCnt != 16'hFFFF) begin
          tbBlkCnt = tbBlkCnt + 16'd1;
        end
      end

      if (bus.in_valid && bus.in_ready) begin
        if (!tbBusy) tbErr = 0;
        if (bus.in_last && tbIdx != BLOCK_PIXELS - 1) tbErr = 1;
        e.data = ycc(bus.in_data);
        e.bs   = (tbIdx == 0);
        e.be   = (tbIdx == BLOCK_PIXELS - 1);
        e.fe   = bus.in_last;
        sb.push_back(e);
        tbIdx  = bus.in_last ? 0 : (tbIdx + 1) % BLOCK_PIXELS;
        tbBusy = 1;
        if (bus.in_last) tbDrain = 1;
      end

      prevStall = bus.out_valid && !bus.out_ready;
      prevData  = bus.out_data;
    end
  end

  // Downstream ready: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: begin
          bus.out_ready = ((readyK % 4) == 0) || ((readyK % 4) == 3);
          readyK++;
        end
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Offer one pixel after 'gap' idle cycles and hold it until accepted
  task automatic applyStimulus(input logic [23:0] d, input logic last, input int gap);
    int n;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic sendFrame(input int n, input bit red, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      applyStimulus(red ? 24'h0000FF : 24'($urandom), (i == n - 1),
                    bubbles ? int'($urandom_range(0, 1)) : 0);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int c0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    latArm = 0; latAccSeen = 0; latOutSeen = 0;

    @(negedge clk);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_conv_enable", conv_enable, 0);
    checkOutput("rst_block_count", block_count, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single block, always ready");
    latArm = 1;
    c0 = outCount;
    sendFrame(64, 0, 0);
    waitIdle();
    latArm = 0;
    checkOutput("t1_count", outCount - c0, 64);
    checkOutput("t1_latency", latOutCyc - latAccCyc, 3);
    checkOutput("t1_consecutive", fendCyc - latOutCyc, 63);
    checkOutput("t1_block_count", block_count, 0);

    $display("[TB] backpressure with red pixels");
    readyMode = 1;
    c0 = outCount;
    sendFrame(64, 1, 0);
    waitIdle();
    readyMode = 0;
    checkOutput("t2_count", outCount - c0, 64);

    $display("[TB] input bubbles over two blocks");
    c0 = outCount;
    sendFrame(128, 0, 1);
    waitIdle();
    checkOutput("t3_count", outCount - c0, 128);
    checkOutput("t3_block_count", block_count, 0);

    $display("[TB] drain gating with back-to-back frames");
    readyMode = 2;
    c0 = outCount;
    sendFrame(64, 0, 0);
    sendFrame(64, 0, 0);
    waitIdle();
    readyMode = 0;
    checkOutput("t4_count", outCount - c0, 128);

    $display("[TB] short frame");
    c0 = outCount;
    sendFrame(11, 0, 0);
    waitIdle();
    checkOutput("t5_count", outCount - c0, 11);
    checkOutput("t5_frame_err_set", frame_err, 1);
    sendFrame(64, 0, 0);
    waitIdle();
    checkOutput("t5_frame_err_clear", frame_err, 0);

    $display("[TB] async reset mid-block");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(24'($urandom), 1'b0, 0);
    end
    checkOutput("t6_pipe_full", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_out_valid", bus.out_valid, 0);
    checkOutput("t6_in_ready", bus.in_ready, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_conv_enable", conv_enable, 0);
    @(negedge clk);
    #7 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t6_quiet", bus.out_valid, 0);
    c0 = outCount;
    sendFrame(64, 0, 0);
    waitIdle();
    checkOutput("t6_recover_count", outCount - c0, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
